// File: rtl/normalize_stage_if.sv
// Handshake and data bundle for the normalize stage: upstream (in_*) and
// downstream (out_*) sides in one interface. The DUT uses the slave view,
// whoever drives the stage and consumes its result uses the master view.
interface normalize_stage_if #(
  parameter int MANT_WIDTH = 28,
  parameter int EXP_WIDTH  = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [MANT_WIDTH-1:0] in_mantissa;
  logic [EXP_WIDTH-1:0]  in_exponent;
  logic                  out_valid;
  logic                  out_ready;
  logic [MANT_WIDTH-1:0] out_mantissa;
  logic [EXP_WIDTH-1:0]  out_exponent;
  logic                  out_zero;
  logic                  out_underflow;

  modport slave (
    input  in_valid, in_mantissa, in_exponent, out_ready,
    output in_ready, out_valid, out_mantissa, out_exponent, out_zero, out_underflow
  );

  modport master (
    output in_valid, in_mantissa, in_exponent, out_ready,
    input  in_ready, out_valid, out_mantissa, out_exponent, out_zero, out_underflow
  );
endinterface

// File: rtl/normalize_stage.sv
// Two-stage normalizer: stage 1 registers the leading-zero count (built from
// 4-bit group detectors), stage 2 shifts the mantissa left and debits the
// exponent, clamping at exponent 0 for subnormal results.
module normalize_stage #(
  parameter int MANT_WIDTH = 28,
  parameter int EXP_WIDTH  = 10
) (
  input logic              clk,
  input logic              reset,
  normalize_stage_if.slave bus
);
  localparam int LZC_W = $clog2(MANT_WIDTH + 1);
  localparam int NGRP  = MANT_WIDTH / 4;

  logic                  r_s1_valid;
  logic [MANT_WIDTH-1:0] r_s1_mant;
  logic [EXP_WIDTH-1:0]  r_s1_exp;
  logic [LZC_W-1:0]      r_s1_lzc;
  logic                  r_s1_zero;

  logic                  r_s2_valid;
  logic [MANT_WIDTH-1:0] r_s2_mant;
  logic [EXP_WIDTH-1:0]  r_s2_exp;
  logic                  r_s2_zero;
  logic                  r_s2_uf;

  logic                  w_s1_adv;
  logic                  w_s2_adv;
  logic [1:0]            w_grp_cnt [NGRP];
  logic [NGRP-1:0]       w_grp_nz;
  logic [LZC_W-1:0]      w_lzc;
  logic                  w_zero;
  logic [EXP_WIDTH-1:0]  w_lzc_ext;
  logic [EXP_WIDTH-1:0]  w_shift;
  logic                  w_uf;

  assign w_s2_adv     = !r_s2_valid || bus.out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign bus.in_ready = w_s1_adv && !reset;

  // Group g = 0 is the most significant nibble of the mantissa.
  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    logic [3:0] w_nib;
    assign w_nib        = bus.in_mantissa[MANT_WIDTH-1-4*g -: 4];
    assign w_grp_nz[g]  = |w_nib;
    assign w_grp_cnt[g] = w_nib[3] ? 2'd0 :
                          w_nib[2] ? 2'd1 :
                          w_nib[1] ? 2'd2 : 2'd3;
  end

  // Most significant non-zero group wins; all-zero input reports MANT_WIDTH.
  always_comb begin
    w_lzc  = LZC_W'(MANT_WIDTH);
    w_zero = 1'b1;
    for (int g = 0; g < NGRP; g++) begin
      if (w_zero && w_grp_nz[g]) begin
        w_lzc  = LZC_W'(4 * g) + {{(LZC_W-2){1'b0}}, w_grp_cnt[g]};
        w_zero = 1'b0;
      end
    end
  end

  // Shift is limited by the exponent so the result never goes below exponent 0.
  assign w_lzc_ext = EXP_WIDTH'(r_s1_lzc);
  assign w_uf      = w_lzc_ext > r_s1_exp;
  assign w_shift   = w_uf ? r_s1_exp : w_lzc_ext;

  // Stage 1: capture the operand and its leading-zero count on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mant  <= '0;
      r_s1_exp   <= '0;
      r_s1_lzc   <= '0;
      r_s1_zero  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_mant <= bus.in_mantissa;
        r_s1_exp  <= bus.in_exponent;
        r_s1_lzc  <= w_lzc;
        r_s1_zero <= w_zero;
      end
    end
  end

  // Stage 2: apply the clamped shift and register the result flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_mant  <= '0;
      r_s2_exp   <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_uf    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        if (r_s1_zero) begin
          r_s2_mant <= '0;
          r_s2_exp  <= '0;
          r_s2_zero <= 1'b1;
          r_s2_uf   <= 1'b0;
        end else begin
          r_s2_mant <= r_s1_mant << w_shift;
          r_s2_exp  <= r_s1_exp - w_shift;
          r_s2_zero <= 1'b0;
          r_s2_uf   <= w_uf;
        end
      end
    end
  end

  assign bus.out_valid     = r_s2_valid;
  assign bus.out_mantissa  = r_s2_mant;
  assign bus.out_exponent  = r_s2_exp;
  assign bus.out_zero      = r_s2_zero;
  assign bus.out_underflow = r_s2_uf;
endmodule

// File: tb/tb_normalize_stage.sv
// Scoreboard bench for normalize_stage: the driver pushes hand-computed
// results on accept, an independent monitor pops and compares on each
// output transfer, tracks occupancy for in_ready and checks stall stability.
module tb_normalize_stage;
  localparam int MW = 28;
  localparam int EW = 10;

  typedef struct packed {
    logic [MW-1:0] m;
    logic [EW-1:0] e;
    logic          z;
    logic          u;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  normalize_stage_if #(.MANT_WIDTH(MW), .EXP_WIDTH(EW)) bus ();
  normalize_stage #(.MANT_WIDTH(MW), .EXP_WIDTH(EW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;
  int   occ = 0;
  bit   have_hold = 0;
  res_t hold;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // out_ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = never ready
  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (bus.out_ready === 1'b1) ? 1'b0 : 1'b1;
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor: samples between edges, after stimulus for the coming edge has settled
  always @(negedge clk) begin
    res_t cur;
    #2;
    if (reset) begin
      occ = 0;
      have_hold = 0;
    end else begin
      check("in_ready", 64'(bus.in_ready), 64'(!(occ == 2 && bus.out_ready !== 1'b1)));
      cur = '{bus.out_mantissa, bus.out_exponent, bus.out_zero, bus.out_underflow};
      if (have_hold) begin
        check("stall_valid", 64'(bus.out_valid), 64'(1));
        check("stall_hold", 64'(cur), 64'(hold));
      end
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready === 1'b1) begin
          have_hold = 0;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output actual=%0h required=none", cur);
          end else begin
            res_t x;
            x = sb.pop_front();
            check("out_mantissa", 64'(cur.m), 64'(x.m));
            check("out_exponent", 64'(cur.e), 64'(x.e));
            check("out_zero", 64'(cur.z), 64'(x.z));
            check("out_underflow", 64'(cur.u), 64'(x.u));
          end
        end else begin
          hold = cur;
          have_hold = 1;
        end
      end else begin
        have_hold = 0;
      end
      occ = occ + int'(bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
                - int'(bus.out_valid === 1'b1 && bus.out_ready === 1'b1);
    end
  end

  task automatic send(input logic [MW-1:0] m, input logic [EW-1:0] e, input res_t x);
    bit done;
    done = 0;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_mantissa = m;
    bus.in_exponent = e;
    for (int t = 0; t < 50 && !done; t++) begin
      #1;
      if (bus.in_ready === 1'b1) begin
        sb.push_back(x);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.in_mantissa = 'x;
    bus.in_exponent = 'x;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_mantissa = '0;
    bus.in_exponent = '0;
    rdy_mode = 0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_mantissa", 64'(bus.out_mantissa), 64'(0));
    check("rst_out_exponent", 64'(bus.out_exponent), 64'(0));
    check("rst_out_zero", 64'(bus.out_zero), 64'(0));
    check("rst_out_underflow", 64'(bus.out_underflow), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

    // directed vectors with continuous out_ready
    send(28'h0800000, 10'd100, '{28'h8000000, 10'd96, 1'b0, 1'b0});
    send(28'h0000000, 10'd50,  '{28'h0000000, 10'd0,  1'b1, 1'b0});
    send(28'h0000001, 10'd10,  '{28'h0000400, 10'd0,  1'b0, 1'b1});
    send(28'h8000000, 10'd0,   '{28'h8000000, 10'd0,  1'b0, 1'b0});
    send(28'h0000100, 10'd19,  '{28'h8000000, 10'd0,  1'b0, 1'b0});
    send(28'h3000000, 10'd5,   '{28'hC000000, 10'd3,  1'b0, 1'b0});
    send(28'h0F00000, 10'd4,   '{28'hF000000, 10'd0,  1'b0, 1'b0});
    send(28'h1000000, 10'd200, '{28'h8000000, 10'd197, 1'b0, 1'b0});
    idle();
    drain();

    // back-to-back with out_ready toggling
    rdy_mode = 1;
    send(28'h0000001, 10'd30,   '{28'h8000000, 10'd3,    1'b0, 1'b0});
    send(28'h0000050, 10'd30,   '{28'hA000000, 10'd9,    1'b0, 1'b0});
    send(28'h0001234, 10'd12,   '{28'h1234000, 10'd0,    1'b0, 1'b1});
    send(28'hFFFFFFF, 10'd7,    '{28'hFFFFFFF, 10'd7,    1'b0, 1'b0});
    send(28'h0000000, 10'd3,    '{28'h0000000, 10'd0,    1'b1, 1'b0});
    send(28'h0400000, 10'd1,    '{28'h0800000, 10'd0,    1'b0, 1'b1});
    send(28'h00ABCDE, 10'd40,   '{28'hABCDE00, 10'd32,   1'b0, 1'b0});
    send(28'h7FFFFFF, 10'd1023, '{28'hFFFFFFE, 10'd1022, 1'b0, 1'b0});
    idle();
    drain();

    // reset with two items in flight
    rdy_mode = 2;
    send(28'h0000010, 10'd50, '{28'h8000000, 10'd27, 1'b0, 1'b0});
    send(28'h0000020, 10'd50, '{28'h8000000, 10'd28, 1'b0, 1'b0});
    idle();
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    reset = 1'b0;
    #2;
    check("mid_rst_release_in_ready", 64'(bus.in_ready), 64'(1));
    rdy_mode = 0;
    repeat (6) @(negedge clk);
    send(28'h0020000, 10'd20, '{28'h8000000, 10'd10, 1'b0, 1'b0});
    idle();
    drain();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
